// File: rtl/lifo_guard.sv
// Registered command stage in front of the lifo_se data stack: tracks depth, rejects illegal
// stack effects with underflow/overflow flags, and stalls ZDUP while the top-of-stack is in flight.
// Optional build macro LIFO_GUARD_STICKY_EN: latch error flags until i_clr and block requests meanwhile.
module lifo_guard #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 12,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_se,
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] i_s0,
  output logic [2:0]       o_se,
  output logic [WIDTH-1:0] o_data,
  output logic [DW-1:0]    o_depth,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_uflow,
  output logic             o_oflow,
  input  logic             i_clr
);

  localparam logic [2:0] NO_SE   = 3'd0;
  localparam logic [2:0] DROP_SE = 3'd1;
  localparam logic [2:0] PUSH_SE = 3'd2;
  localparam logic [2:0] RPLC_SE = 3'd3;
  localparam logic [2:0] SWAP_SE = 3'd4;
  localparam logic [2:0] OVER_SE = 3'd5;
  localparam logic [2:0] ROT3_SE = 3'd6;
  localparam logic [2:0] ZDUP_SE = 3'd7;

  localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);
  localparam logic [DW-1:0] ONE_C   = DW'(1);
  localparam logic [DW-1:0] TWO_C   = DW'(2);
  localparam logic [DW-1:0] THREE_C = DW'(3);

  logic [2:0]       se_p0;
  logic [WIDTH-1:0] data_p0;
  logic [DW-1:0]    depth_p0;
  logic             pend_p0;
  logic             uflow_p0;
  logic             oflow_p0;

  logic             err_block;
  logic             acc;
  logic             uf;
  logic             of;
  logic             issue;
  logic [DW-1:0]    depth_nxt;

`ifdef LIFO_GUARD_STICKY_EN
  // A clear takes priority over any request presented in the same cycle.
  assign err_block = uflow_p0 | oflow_p0 | i_clr;
`else
  logic unused_clr;
  assign unused_clr = i_clr;
  assign err_block  = 1'b0;
`endif

  assign o_ready = !(pend_p0 && (i_se == ZDUP_SE)) && !err_block;
  assign acc     = i_valid && o_ready;

  // Legality of the requested effect against the depth at acceptance.
  always_comb begin
    uf        = 1'b0;
    of        = 1'b0;
    depth_nxt = depth_p0;
    case (i_se)
      DROP_SE: begin
        if (depth_p0 == '0) uf = 1'b1;
        else                depth_nxt = depth_p0 - ONE_C;
      end
      PUSH_SE: begin
        if (depth_p0 == DEPTH_C) of = 1'b1;
        else                     depth_nxt = depth_p0 + ONE_C;
      end
      RPLC_SE: uf = (depth_p0 < ONE_C);
      SWAP_SE: uf = (depth_p0 < TWO_C);
      OVER_SE: begin
        if (depth_p0 < TWO_C)           uf = 1'b1;
        else if (depth_p0 == DEPTH_C)   of = 1'b1;
        else                            depth_nxt = depth_p0 + ONE_C;
      end
      ROT3_SE: uf = (depth_p0 < THREE_C);
      ZDUP_SE: begin
        if (depth_p0 == '0)             uf = 1'b1;
        else if (i_s0 != '0) begin
          if (depth_p0 == DEPTH_C)      of = 1'b1;
          else                          depth_nxt = depth_p0 + ONE_C;
        end
      end
      default: ;
    endcase
  end

  assign issue = acc && !uf && !of && (i_se != NO_SE);

  // ---- stage p0: registered command to the stack ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      se_p0    <= NO_SE;
      data_p0  <= '0;
      depth_p0 <= '0;
      pend_p0  <= 1'b0;
      uflow_p0 <= 1'b0;
      oflow_p0 <= 1'b0;
    end else begin
      se_p0   <= issue ? i_se : NO_SE;
      pend_p0 <= issue;
      if (issue) data_p0 <= i_data;
      if (acc)   depth_p0 <= depth_nxt;
`ifdef LIFO_GUARD_STICKY_EN
      if (i_clr) begin
        uflow_p0 <= 1'b0;
        oflow_p0 <= 1'b0;
      end else begin
        uflow_p0 <= uflow_p0 | (acc && uf);
        oflow_p0 <= oflow_p0 | (acc && of);
      end
`else
      uflow_p0 <= acc && uf;
      oflow_p0 <= acc && of;
`endif
    end
  end

  assign o_se    = se_p0;
  assign o_data  = data_p0;
  assign o_depth = depth_p0;
  assign o_empty = (depth_p0 == '0);
  assign o_full  = (depth_p0 == DEPTH_C);
  assign o_uflow = uflow_p0;
  assign o_oflow = oflow_p0;

endmodule
